ppu_reg_responder: RTL and testbench

- CPU-bus responder for the PPU register window $2000-$2007, mirrored every 8 bytes across $2000-$3FFF.
- It is the target end of the bus that NES_CPU masters over nes_if. It decodes CPU reads and writes, holds PPUCTRL, PPUMASK, scroll and OAM address, and runs the $2006/$2007 VRAM address and data port.
- It owns the vblank flag and drives the NMI line back to the CPU.
- It bridges $2007 accesses to PPU VRAM through a req/ack handshake.

---
 rtl/nes_ppu_pkg.sv | 23 ++
 rtl/ppu_vram_port.sv | 98 +++++++++
 rtl/ppu_reg_responder.sv | 145 ++++++++++++++
 tb/tb_ppu_reg_responder.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nes_ppu_pkg.sv
// Shared definitions for the PPU CPU-side register window: register
// offsets, the VRAM port state encoding and the VRAM address steps.
package nes_ppu_pkg;

  localparam logic [2:0] PPUCTRL   = 3'd0;
  localparam logic [2:0] PPUMASK   = 3'd1;
  localparam logic [2:0] PPUSTATUS = 3'd2;
  localparam logic [2:0] OAMADDR   = 3'd3;
  localparam logic [2:0] OAMDATA   = 3'd4;
  localparam logic [2:0] PPUSCROLL = 3'd5;
  localparam logic [2:0] PPUADDR   = 3'd6;
  localparam logic [2:0] PPUDATA   = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2
  } vram_state_e;

  localparam int INC1  = 1;
  localparam int INC32 = 32;

endpackage

// File: rtl/ppu_vram_port.sv
// $2006/$2007 VRAM address and data port: owns the VRAM address register
// (vaddr), the $2007 read buffer and the request state machine toward PPU VRAM.
//
// Handshake: vram_req rises on the edge that accepts a $2007 access and stays
// high, with vram_we/vram_addr/vram_wdata stable, until the edge on which
// vram_ack is sampled high; vram_req falls on that same edge. vram_rdata is
// only looked at together with vram_ack during a read. An ack while idle is
// ignored, so an ack arriving after a reset has no effect.
module ppu_vram_port
  import nes_ppu_pkg::*;
#(
  parameter int VADDR_W = 14
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               acc,
  input  logic               rw,
  input  logic [7:0]         wdata,
  input  logic               addr_wr,
  input  logic               w,
  input  logic               inc32,
  input  logic [7:0]         vram_rdata,
  input  logic               vram_ack,
  output logic               vram_req,
  output logic               vram_we,
  output logic [VADDR_W-1:0] vram_addr,
  output logic [7:0]         vram_wdata,
  output logic [7:0]         read_buf,
  output vram_state_e        state
);

  vram_state_e        state_next;
  logic [VADDR_W-1:0] vaddr;
  logic [VADDR_W-1:0] vaddr_base;
  logic [VADDR_W-1:0] inc_val;
  logic               start_wr;
  logic               start_rd;
  logic               complete;

  assign start_wr = acc && !rw && (state == IDLE);
  assign start_rd = acc &&  rw && (state == IDLE);
  assign complete = vram_ack && (state != IDLE);
  assign inc_val  = inc32 ? VADDR_W'(INC32) : VADDR_W'(INC1);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next state: accept a $2007 access when idle, finish on ack
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start_wr)      state_next = WR;
        else if (start_rd) state_next = RD;
      end
      WR, RD: begin
        if (vram_ack) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs decoded from the state
  always_comb begin
    vram_req = (state != IDLE);
    vram_we  = (state == WR);
  end

  // A $2006 write may land while a request is in flight; the completion
  // increment is applied on top of the freshly written address.
  always_comb begin
    vaddr_base = vaddr;
    if (addr_wr) begin
      if (!w) vaddr_base[VADDR_W-1:8] = wdata[VADDR_W-9:0];
      else    vaddr_base[7:0]         = wdata;
    end
  end

  // Address register, latched request fields and read buffer
  always_ff @(posedge clk) begin
    if (rst) begin
      vaddr      <= '0;
      vram_addr  <= '0;
      vram_wdata <= 8'h00;
      read_buf   <= 8'h00;
    end else begin
      if (complete) vaddr <= vaddr_base + inc_val;
      else          vaddr <= vaddr_base;
      if (start_wr || start_rd) vram_addr  <= vaddr;
      if (start_wr)             vram_wdata <= wdata;
      if (complete && (state == RD)) read_buf <= vram_rdata;
    end
  end

endmodule

// File: rtl/ppu_reg_responder.sv
// CPU-bus target for the PPU register window ($2000-$2007, mirrored).
// Holds the CPU-visible PPU registers, the vblank flag and NMI line, and
// forwards $2006/$2007 traffic to the VRAM port.
module ppu_reg_responder
  import nes_ppu_pkg::*;
#(
  parameter int VADDR_W     = 14,
  parameter bit OPEN_BUS_EN = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               acc_en,
  input  logic               rw,
  input  logic [2:0]         addr,
  input  logic [7:0]         wdata,
  output logic [7:0]         rdata,
  output logic               b_nmi,
  input  logic               vblank_set,
  input  logic               vblank_clr,
  input  logic               spr0_hit,
  input  logic               spr_ovf,
  output logic [7:0]         ppu_ctrl,
  output logic [7:0]         ppu_mask,
  output logic [7:0]         scroll_x,
  output logic [7:0]         scroll_y,
  output logic [7:0]         oam_addr,
  output logic               oam_we,
  output logic [7:0]         oam_wdata,
  input  logic [7:0]         oam_rdata,
  output logic               vram_req,
  output logic               vram_we,
  output logic [VADDR_W-1:0] vram_addr,
  output logic [7:0]         vram_wdata,
  input  logic [7:0]         vram_rdata,
  input  logic               vram_ack,
  output logic               drop
);

  logic        wr_en;
  logic        rd_en;
  logic        status_rd;
  logic        acc_data;
  logic        addr_wr;
  logic        vblank;
  logic        w_toggle;
  logic [7:0]  open_bus;
  logic [7:0]  bus_val;
  logic [7:0]  read_buf;
  logic [7:0]  rd_val;
  vram_state_e vram_state;

  assign wr_en     = acc_en && !rw;
  assign rd_en     = acc_en &&  rw;
  assign status_rd = rd_en && (addr == PPUSTATUS);
  assign acc_data  = acc_en && (addr == PPUDATA);
  assign addr_wr   = wr_en && (addr == PPUADDR);
  assign bus_val   = OPEN_BUS_EN ? open_bus : 8'h00;

  // Read mux; a vblank_set coinciding with the status read is reported as 0
  always_comb begin
    rd_val = bus_val;
    case (addr)
      PPUSTATUS: rd_val = {vblank && !vblank_set, spr0_hit, spr_ovf, bus_val[4:0]};
      OAMDATA:   rd_val = oam_rdata;
      PPUDATA:   rd_val = read_buf;
      default:   rd_val = bus_val;
    endcase
  end

  // CPU-written registers, OAM write pulse and auto-increment
  always_ff @(posedge clk) begin
    if (rst) begin
      ppu_ctrl  <= 8'h00;
      ppu_mask  <= 8'h00;
      scroll_x  <= 8'h00;
      scroll_y  <= 8'h00;
      oam_addr  <= 8'h00;
      oam_we    <= 1'b0;
      oam_wdata <= 8'h00;
      open_bus  <= 8'h00;
      w_toggle  <= 1'b0;
    end else begin
      oam_we <= wr_en && (addr == OAMDATA);
      if (wr_en) open_bus <= wdata;
      if (wr_en && (addr == PPUCTRL)) ppu_ctrl <= wdata;
      if (wr_en && (addr == PPUMASK)) ppu_mask <= wdata;
      if (wr_en && (addr == OAMDATA)) oam_wdata <= wdata;
      // Explicit $2003 writes take priority over the post-write increment
      if (wr_en && (addr == OAMADDR)) oam_addr <= wdata;
      else if (oam_we)                oam_addr <= oam_addr + 8'd1;
      if (wr_en && (addr == PPUSCROLL)) begin
        if (!w_toggle) scroll_x <= wdata;
        else           scroll_y <= wdata;
      end
      if (status_rd) w_toggle <= 1'b0;
      else if (wr_en && ((addr == PPUSCROLL) || (addr == PPUADDR))) w_toggle <= ~w_toggle;
    end
  end

  // Vblank flag (clear beats set, status read suppresses a same-cycle set) and NMI
  always_ff @(posedge clk) begin
    if (rst) begin
      vblank <= 1'b0;
      b_nmi  <= 1'b1;
    end else begin
      if (vblank_clr)      vblank <= 1'b0;
      else if (status_rd)  vblank <= 1'b0;
      else if (vblank_set) vblank <= 1'b1;
      b_nmi <= ~(ppu_ctrl[7] & vblank);
    end
  end

  // Registered read data and busy-port drop pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= 8'h00;
      drop  <= 1'b0;
    end else begin
      if (rd_en) rdata <= rd_val;
      drop <= acc_data && (vram_state != IDLE);
    end
  end

  ppu_vram_port #(
    .VADDR_W (VADDR_W)
  ) u_vram_port (
    .clk        (clk),
    .rst        (rst),
    .acc        (acc_data),
    .rw         (rw),
    .wdata      (wdata),
    .addr_wr    (addr_wr),
    .w          (w_toggle),
    .inc32      (ppu_ctrl[2]),
    .vram_rdata (vram_rdata),
    .vram_ack   (vram_ack),
    .vram_req   (vram_req),
    .vram_we    (vram_we),
    .vram_addr  (vram_addr),
    .vram_wdata (vram_wdata),
    .read_buf   (read_buf),
    .state      (vram_state)
  );

endmodule

// File: tb/tb_ppu_reg_responder.sv
// Bench for ppu_reg_responder: directed steps followed by a randomized
// phase, all checked against a register-level model of the PPU window.
module tb_ppu_reg_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        acc_en = 1'b0;
  logic        rw = 1'b0;
  logic [2:0]  addr = 3'd0;
  logic [7:0]  wdata = 8'h00;
  logic [7:0]  rdata;
  logic        b_nmi;
  logic        vblank_set = 1'b0;
  logic        vblank_clr = 1'b0;
  logic        spr0_hit = 1'b0;
  logic        spr_ovf = 1'b0;
  logic [7:0]  ppu_ctrl, ppu_mask, scroll_x, scroll_y, oam_addr;
  logic        oam_we;
  logic [7:0]  oam_wdata;
  logic [7:0]  oam_rdata = 8'h00;
  logic        vram_req, vram_we;
  logic [13:0] vram_addr;
  logic [7:0]  vram_wdata;
  logic [7:0]  vram_rdata = 8'h00;
  logic        vram_ack = 1'b0;
  logic        drop;

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [7:0] m_ctrl, m_mask, m_sx, m_sy, m_oam, m_ob, m_buf;
  logic       m_vbl, m_w, m_busy, m_busy_rd;
  int         m_vaddr;
  int         m_req_addr;
  logic [7:0] m_req_wdata;

  ppu_reg_responder #(.VADDR_W(14), .OPEN_BUS_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .acc_en(acc_en), .rw(rw), .addr(addr), .wdata(wdata),
    .rdata(rdata), .b_nmi(b_nmi), .vblank_set(vblank_set), .vblank_clr(vblank_clr),
    .spr0_hit(spr0_hit), .spr_ovf(spr_ovf), .ppu_ctrl(ppu_ctrl), .ppu_mask(ppu_mask),
    .scroll_x(scroll_x), .scroll_y(scroll_y), .oam_addr(oam_addr), .oam_we(oam_we),
    .oam_wdata(oam_wdata), .oam_rdata(oam_rdata), .vram_req(vram_req), .vram_we(vram_we),
    .vram_addr(vram_addr), .vram_wdata(vram_wdata), .vram_rdata(vram_rdata),
    .vram_ack(vram_ack), .drop(drop)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ctrl = 8'h00; m_mask = 8'h00; m_sx = 8'h00; m_sy = 8'h00; m_oam = 8'h00;
    m_ob = 8'h00; m_buf = 8'h00; m_vbl = 1'b0; m_w = 1'b0; m_busy = 1'b0;
    m_busy_rd = 1'b0; m_vaddr = 0; m_req_addr = 0; m_req_wdata = 8'h00;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    check("rst_rdata", 16'(rdata), 16'h0);
    check("rst_b_nmi", 16'(b_nmi), 16'h1);
    check("rst_ctrl", 16'(ppu_ctrl), 16'h0);
    check("rst_mask", 16'(ppu_mask), 16'h0);
    check("rst_scroll", {scroll_x, scroll_y}, 16'h0);
    check("rst_oam_addr", 16'(oam_addr), 16'h0);
    check("rst_vram_req", 16'(vram_req), 16'h0);
    check("rst_oam_we", 16'(oam_we), 16'h0);
    check("rst_drop", 16'(drop), 16'h0);
  endtask

  // Check a request that is in flight against what the model recorded
  task automatic check_req(input string tag, input logic we);
    check({tag, "_req"}, 16'(vram_req), 16'h1);
    check({tag, "_we"}, 16'(vram_we), 16'(we));
    check({tag, "_addr"}, 16'(vram_addr), 16'(m_req_addr));
    if (we) check({tag, "_wdata"}, 16'(vram_wdata), 16'(m_req_wdata));
  endtask

  task automatic do_wr(input logic [2:0] a, input logic [7:0] d);
    logic was_busy;
    logic [7:0] old_oam;
    was_busy = m_busy;
    old_oam = m_oam;
    acc_en = 1'b1; rw = 1'b0; addr = a; wdata = d;
    tick();
    acc_en = 1'b0;
    m_ob = d;
    case (a)
      3'd0: m_ctrl = d;
      3'd1: m_mask = d;
      3'd3: m_oam = d;
      3'd4: begin
        check("oam_we_pulse", 16'(oam_we), 16'h1);
        check("oam_wdata", 16'(oam_wdata), 16'(d));
        check("oam_addr_at_we", 16'(oam_addr), 16'(old_oam));
        m_oam = 8'((int'(m_oam) + 1) % 256);
      end
      3'd5: begin
        if (!m_w) m_sx = d; else m_sy = d;
        m_w = !m_w;
      end
      3'd6: begin
        if (!m_w) m_vaddr = (int'(d) % 64) * 256 + (m_vaddr % 256);
        else      m_vaddr = (m_vaddr / 256) * 256 + int'(d);
        m_w = !m_w;
      end
      3'd7: begin
        if (!was_busy) begin
          m_busy = 1'b1; m_busy_rd = 1'b0;
          m_req_addr = m_vaddr; m_req_wdata = d;
        end
        check("wr7_drop", 16'(drop), 16'(was_busy));
        check_req("wr7", !m_busy_rd);
      end
      default: ;
    endcase
  endtask

  task automatic do_rd(input logic [2:0] a, input logic vset, output logic [7:0] got);
    logic [7:0] exp;
    logic was_busy;
    was_busy = m_busy;
    case (a)
      3'd2: exp = {m_vbl && !vset, spr0_hit, spr_ovf, m_ob[4:0]};
      3'd4: exp = oam_rdata;
      3'd7: exp = m_buf;
      default: exp = m_ob;
    endcase
    acc_en = 1'b1; rw = 1'b1; addr = a; vblank_set = vset;
    tick();
    acc_en = 1'b0; vblank_set = 1'b0;
    got = rdata;
    check($sformatf("rd%0d_rdata", a), 16'(rdata), 16'(exp));
    if (a == 3'd2) begin
      m_vbl = 1'b0;
      m_w = 1'b0;
    end else if (vset) begin
      m_vbl = 1'b1;
    end
    if (a == 3'd7) begin
      if (!was_busy) begin
        m_busy = 1'b1; m_busy_rd = 1'b1; m_req_addr = m_vaddr;
      end
      check("rd7_drop", 16'(drop), 16'(was_busy));
      check_req("rd7", !m_busy_rd);
    end
  endtask

  task automatic do_ack(input logic [7:0] d);
    vram_ack = 1'b1; vram_rdata = d;
    tick();
    vram_ack = 1'b0;
    if (m_busy) begin
      if (m_busy_rd) m_buf = d;
      m_vaddr = (m_vaddr + (m_ctrl[2] ? 32 : 1)) % 16384;
      m_busy = 1'b0;
    end
    check("ack_req_low", 16'(vram_req), 16'h0);
  endtask

  task automatic vbl_pulse(input logic set, input logic clr);
    vblank_set = set; vblank_clr = clr;
    tick();
    vblank_set = 1'b0; vblank_clr = 1'b0;
    if (clr) m_vbl = 1'b0;
    else if (set) m_vbl = 1'b1;
  endtask

  // One quiet cycle, then compare all register outputs to the model
  task automatic idle_check();
    tick();
    check("ctrl", 16'(ppu_ctrl), 16'(m_ctrl));
    check("mask", 16'(ppu_mask), 16'(m_mask));
    check("scroll_x", 16'(scroll_x), 16'(m_sx));
    check("scroll_y", 16'(scroll_y), 16'(m_sy));
    check("oam_addr", 16'(oam_addr), 16'(m_oam));
    check("b_nmi", 16'(b_nmi), 16'(!(m_ctrl[7] && m_vbl)));
    check("vram_req", 16'(vram_req), 16'(m_busy));
    check("oam_we_idle", 16'(oam_we), 16'h0);
    check("drop_idle", 16'(drop), 16'h0);
  endtask

  initial begin
    logic [7:0] got;
    int r;
    model_reset();

    // Reset, status read, NMI on vblank with ctrl[7]
    do_reset();
    do_rd(3'd2, 1'b0, got);
    idle_check();
    do_wr(3'd0, 8'h80);
    idle_check();
    vbl_pulse(1'b1, 1'b0);
    idle_check();
    do_rd(3'd2, 1'b0, got);
    check("vbl_bit7", 16'(got[7]), 16'h1);
    idle_check();

    // $2006/$2007 write with +1 increment
    do_wr(3'd6, 8'h21);
    do_wr(3'd6, 8'h08);
    do_wr(3'd7, 8'h5A);
    check("wr_addr_2108", 16'(vram_addr), 16'h2108);
    do_ack(8'h00);
    do_rd(3'd7, 1'b0, got);
    check("addr_2109", 16'(vram_addr), 16'h2109);
    do_ack(8'h33);
    idle_check();

    // Buffered reads with +32 increment and address wrap
    do_wr(3'd0, 8'h04);
    do_wr(3'd6, 8'h3F);
    do_wr(3'd6, 8'hF0);
    do_rd(3'd7, 1'b0, got);
    check("buf_old", 16'(got), 16'h33);
    do_ack(8'hAA);
    do_rd(3'd7, 1'b0, got);
    check("buf_aa", 16'(got), 16'hAA);
    check("addr_wrap", 16'(vram_addr), 16'h0010);
    do_ack(8'hBB);
    do_rd(3'd7, 1'b0, got);
    check("buf_bb", 16'(got), 16'hBB);
    do_ack(8'h00);
    idle_check();

    // OAM data write and address wrap
    do_wr(3'd3, 8'hFF);
    do_wr(3'd4, 8'h12);
    idle_check();
    check("oam_wrap", 16'(oam_addr), 16'h00);

    // Busy port drop, then reset in the middle of a read
    do_wr(3'd0, 8'h00);
    do_wr(3'd7, 8'hC3);
    do_wr(3'd7, 8'h99);
    check("drop_keep_wdata", 16'(vram_wdata), 16'hC3);
    do_ack(8'h00);
    idle_check();
    do_rd(3'd7, 1'b0, got);
    do_reset();
    do_ack(8'h55);
    idle_check();
    do_rd(3'd7, 1'b0, got);
    check("late_ack_addr", 16'(vram_addr), 16'h0000);
    check("late_ack_buf", 16'(got), 16'h00);
    do_ack(8'h66);
    idle_check();

    // Vblank races
    do_rd(3'd2, 1'b1, got);
    idle_check();
    do_rd(3'd2, 1'b0, got);
    check("suppressed", 16'(got[7]), 16'h0);
    vbl_pulse(1'b1, 1'b1);
    idle_check();
    do_rd(3'd2, 1'b0, got);

    // Scroll pair and w toggle
    do_wr(3'd5, 8'h10);
    do_wr(3'd5, 8'h20);
    idle_check();
    do_wr(3'd5, 8'h30);
    idle_check();
    check("w_back_to_x", 16'(scroll_x), 16'h30);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      spr0_hit = 1'($urandom_range(0, 1));
      spr_ovf = 1'($urandom_range(0, 1));
      oam_rdata = 8'($urandom);
      r = $urandom_range(0, 11);
      if (r < 8) begin
        if ($urandom_range(0, 1) == 1) do_rd(3'(r), 1'b0, got);
        else do_wr(3'(r), 8'($urandom));
      end else if (r < 10) begin
        if (m_busy) do_ack(8'($urandom));
      end else begin
        vbl_pulse(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      idle_check();
    end
    if (m_busy) do_ack(8'h00);
    idle_check();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
